// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter slice: default bus widths,
//   starvation counter width/limit and the read-owner encoding.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF     = 16;
   localparam int unsigned DATA_W_DEF     = 16;
   localparam int unsigned STARVE_MAX_DEF = 7;
   // Wide enough for any starvation limit in 1..15.
   localparam int unsigned STARVE_W       = 4;

   // Which requester owns the read data returning in the next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2,
      OWN_H    = 2'd3
   } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the three requester ports (fetch, data, host), the shared read
//   data return and the single-port synchronous memory port.
//   slave  : arbiter side (takes requests, drives grants/rvalid/mem_*).
//   master : requesters plus memory model side.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   // instruction fetch
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   // CPU data
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   // host / debug
   logic              h_req;
   logic              h_we;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_wdata;
   logic              h_gnt;
   logic              h_rvalid;
   // shared read data and CPU stall
   logic [DATA_W-1:0] rdata;
   logic              cpu_stall;
   // memory port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_we, d_addr, d_wdata,
      input  h_req, h_we, h_addr, h_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid,
      output rdata, cpu_stall,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output d_req, d_we, d_addr, d_wdata,
      output h_req, h_we, h_addr, h_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid,
      input  rdata, cpu_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt
//   Saturating host-starvation counter.
//   clk    : rising-edge clock
//   reset  : async active-low reset, clears the count
//   inc    : host waited this cycle (count up, saturating at MAX)
//   clr    : host granted or idle (count returns to 0, wins over inc)
//   at_max : count has reached MAX
module mem_arb_starve_cnt
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   logic [STARVE_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_max) begin
         cnt <= cnt + STARVE_W'(1);
      end
   end

   always_comb begin
      at_max = (cnt == STARVE_W'(MAX));
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Three-way arbiter in front of a single-port synchronous memory
//   (1-cycle read latency). Priority data > fetch > host, except that a host
//   kept waiting for STARVE_MAX cycles wins outright. Grants are
//   combinational; the owner of a read is registered so the matching rvalid
//   fires exactly once in the following cycle.
//   clk   : rising-edge clock
//   reset : async active-low reset
//   bus   : requester ports, shared rdata/cpu_stall, memory port
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   owner_e            owner;
   owner_e            owner_nxt;
   logic              if_gnt;
   logic              d_gnt;
   logic              h_gnt;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              starved;

   mem_arb_starve_cnt #(
      .MAX (STARVE_MAX)
   ) u_starve_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (bus.h_req & ~h_gnt),
      .clr    (h_gnt | ~bus.h_req),
      .at_max (starved)
   );

   // Owner register: loaded every cycle, so an ungranted or write cycle
   // leaves no pending read behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner <= OWN_NONE;
      end else begin
         owner <= owner_nxt;
      end
   end

   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      h_gnt     = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      owner_nxt = OWN_NONE;

      if (bus.h_req && starved) begin
         h_gnt = 1'b1;
      end else if (bus.d_req) begin
         d_gnt = 1'b1;
      end else if (bus.if_req) begin
         if_gnt = 1'b1;
      end else if (bus.h_req) begin
         h_gnt = 1'b1;
      end

      if (if_gnt) begin
         mem_addr  = bus.if_addr;
         owner_nxt = OWN_IF;
      end else if (d_gnt) begin
         mem_we    = bus.d_we;
         mem_addr  = bus.d_addr;
         mem_wdata = bus.d_wdata;
         owner_nxt = bus.d_we ? OWN_NONE : OWN_D;
      end else if (h_gnt) begin
         mem_we    = bus.h_we;
         mem_addr  = bus.h_addr;
         mem_wdata = bus.h_wdata;
         owner_nxt = bus.h_we ? OWN_NONE : OWN_H;
      end
   end

   always_comb begin
      bus.if_gnt    = if_gnt;
      bus.d_gnt     = d_gnt;
      bus.h_gnt     = h_gnt;
      bus.mem_en    = if_gnt | d_gnt | h_gnt;
      bus.mem_we    = mem_we;
      bus.mem_addr  = mem_addr;
      bus.mem_wdata = mem_wdata;
      bus.if_rvalid = (owner == OWN_IF);
      bus.d_rvalid  = (owner == OWN_D);
      bus.h_rvalid  = (owner == OWN_H);
      bus.rdata     = bus.mem_rdata;
      bus.cpu_stall = (bus.if_req & ~if_gnt) | (bus.d_req & ~d_gnt);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a 256-word synchronous memory model
//   driven by the DUT's memory port, a transaction-level reference model of
//   the arbitration rules, a vector table, directed corner sequences and a
//   randomized phase.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned AW   = 16;
   localparam int unsigned DW   = 16;
   localparam int          SMAX = 7;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Physical memory, addressed by the low 8 address bits.
   logic [DW-1:0] phys_mem [256];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) phys_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= phys_mem[bus.mem_addr[7:0]];
      end
   end

   // Reference model state.
   int            tests  = 0;
   int            failed = 0;
   int            m_cnt  = 0;
   int            m_pend = 0;          // 0 none, 1 fetch, 2 data, 3 host
   logic [DW-1:0] m_pend_data;
   logic [DW-1:0] m_mem [256];
   int            m_win;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd;
   logic          m_hreq;

   typedef struct {
      logic          if_req;
      logic [AW-1:0] if_addr;
      logic          d_req;
      logic          d_we;
      logic [AW-1:0] d_addr;
      logic [DW-1:0] d_wdata;
      logic          h_req;
      logic          h_we;
      logic [AW-1:0] h_addr;
      logic [DW-1:0] h_wdata;
      logic [2:0]    exp_gnt;    // {h, d, if}
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic          exp_stall;
   } vec_t;

   vec_t vecs [11];

   function automatic vec_t mk(logic ir, logic [AW-1:0] ia,
                               logic dr, logic dw, logic [AW-1:0] da, logic [DW-1:0] dd,
                               logic hr, logic hw, logic [AW-1:0] ha, logic [DW-1:0] hd,
                               logic [2:0] g, logic we, logic [AW-1:0] ea, logic st);
      vec_t v;
      v.if_req = ir; v.if_addr = ia;
      v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
      v.h_req = hr; v.h_we = hw; v.h_addr = ha; v.h_wdata = hd;
      v.exp_gnt = g; v.exp_we = we; v.exp_addr = ea; v.exp_stall = st;
      return v;
   endfunction

   function automatic logic [DW-1:0] pattern(int i);
      logic [DW-1:0] p;
      p = DW'(i) * 16'h0101;
      return p ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
   endtask

   task automatic apply(input vec_t v);
      bus.if_req = v.if_req; bus.if_addr = v.if_addr;
      bus.d_req = v.d_req; bus.d_we = v.d_we; bus.d_addr = v.d_addr; bus.d_wdata = v.d_wdata;
      bus.h_req = v.h_req; bus.h_we = v.h_we; bus.h_addr = v.h_addr; bus.h_wdata = v.h_wdata;
   endtask

   // Compare every DUT output of the current cycle against the model.
   task automatic settle();
      int            win;
      logic [AW-1:0] ea;
      logic          ew;
      logic [DW-1:0] ed;
      #1;
      if (bus.h_req && m_cnt == SMAX) win = 3;
      else if (bus.d_req)              win = 2;
      else if (bus.if_req)             win = 1;
      else if (bus.h_req)              win = 3;
      else                             win = 0;
      ea = '0; ew = 1'b0; ed = '0;
      case (win)
         1: ea = bus.if_addr;
         2: begin ea = bus.d_addr; ew = bus.d_we; ed = bus.d_wdata; end
         3: begin ea = bus.h_addr; ew = bus.h_we; ed = bus.h_wdata; end
         default: ;
      endcase
      chk("grants", 32'({bus.h_gnt, bus.d_gnt, bus.if_gnt}),
          32'({win == 3, win == 2, win == 1}));
      chk("mem_en", 32'(bus.mem_en), 32'(win != 0));
      chk("mem_we", 32'(bus.mem_we), 32'(ew));
      chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
      chk("cpu_stall", 32'(bus.cpu_stall),
          32'((bus.if_req && win != 1) || (bus.d_req && win != 2)));
      chk("rvalid", 32'({bus.h_rvalid, bus.d_rvalid, bus.if_rvalid}),
          32'({m_pend == 3, m_pend == 2, m_pend == 1}));
      if (m_pend != 0) chk("rdata", 32'(bus.rdata), 32'(m_pend_data));
      m_win = win; m_we = ew; m_addr = ea; m_wd = ed; m_hreq = bus.h_req;
   endtask

   // Advance one clock edge and update the model.
   task automatic tick();
      @(posedge clk);
      if (m_win != 0 && m_we) m_mem[m_addr[7:0]] = m_wd;
      if (!reset) begin
         m_cnt  = 0;
         m_pend = 0;
      end else begin
         if (m_hreq && m_win != 3) m_cnt = (m_cnt < SMAX) ? m_cnt + 1 : SMAX;
         else                      m_cnt = 0;
         if (m_win != 0 && !m_we) begin
            m_pend      = m_win;
            m_pend_data = m_mem[m_addr[7:0]];
         end else begin
            m_pend = 0;
         end
      end
      #1;
   endtask

   initial begin
      idle();
      #1 reset = 1'b0;

      // Reset state.
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("reset_rvalid", 32'({bus.h_rvalid, bus.d_rvalid, bus.if_rvalid}), 32'(0));
         chk("reset_mem_en", 32'(bus.mem_en), 32'(0));
         tick();
      end
      reset = 1'b1;

      // Preload every memory word through host writes.
      for (int i = 0; i < 256; i++) begin
         bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = AW'(i); bus.h_wdata = pattern(i);
         settle();
         tick();
      end
      idle();

      // Single fetch read returns memory data one cycle later.
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 16'h0010; bus.h_wdata = 16'hABCD;
      settle(); tick();
      idle();
      bus.if_req = 1'b1; bus.if_addr = 16'h0010;
      settle();
      chk("fetch_gnt", 32'(bus.if_gnt), 32'(1));
      chk("fetch_addr", 32'(bus.mem_addr), 32'h0010);
      tick();
      idle();
      settle();
      chk("fetch_rvalid", 32'(bus.if_rvalid), 32'(1));
      chk("fetch_rdata", 32'(bus.rdata), 32'hABCD);
      tick();

      // Vector table.
      vecs[0]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b000, 0, 16'h0000, 0);
      vecs[1]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b001, 0, 16'h0010, 0);
      vecs[2]  = mk(1, 16'h0030, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b010, 0, 16'h0020, 1);
      vecs[3]  = mk(1, 16'h0030, 1, 1, 16'h0200, 16'h1234, 0, 0, 16'h0000, 16'h0000, 3'b010, 1, 16'h0200, 1);
      vecs[4]  = mk(1, 16'h0030, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b001, 0, 16'h0030, 0);
      vecs[5]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, 3'b100, 0, 16'h0040, 0);
      vecs[6]  = mk(1, 16'h0060, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0050, 16'hBEEF, 3'b001, 0, 16'h0060, 0);
      vecs[7]  = mk(0, 16'h0000, 1, 0, 16'h0070, 16'h0000, 1, 1, 16'h0050, 16'hBEEF, 3'b010, 0, 16'h0070, 0);
      vecs[8]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0050, 16'hBEEF, 3'b100, 1, 16'h0050, 0);
      vecs[9]  = mk(1, 16'h0060, 1, 1, 16'h0090, 16'h5555, 1, 0, 16'h00A0, 16'h0000, 3'b010, 1, 16'h0090, 1);
      vecs[10] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b000, 0, 16'h0000, 0);
      for (int i = 0; i < 11; i++) begin
         apply(vecs[i]);
         settle();
         chk($sformatf("vec%0d_gnt", i), 32'({bus.h_gnt, bus.d_gnt, bus.if_gnt}), 32'(vecs[i].exp_gnt));
         chk($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_we));
         chk($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_addr));
         chk($sformatf("vec%0d_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].exp_stall));
         tick();
      end

      // Host starved behind a continuous data stream wins in cycle 8 only.
      bus.h_req = 1'b1; bus.h_addr = 16'h0100;
      bus.d_req = 1'b1; bus.d_addr = 16'h0101;
      for (int k = 1; k <= 10; k++) begin
         settle();
         chk($sformatf("starve_h_gnt_c%0d", k), 32'(bus.h_gnt), 32'(k == 8));
         chk($sformatf("starve_d_gnt_c%0d", k), 32'(bus.d_gnt), 32'(k != 8));
         tick();
      end
      idle();

      // Back-to-back fetch reads give consecutive rvalid pulses.
      for (int k = 0; k < 5; k++) begin
         idle();
         if (k < 4) begin
            bus.if_req = 1'b1; bus.if_addr = AW'(16'h0020 + k);
         end
         settle();
         if (k > 0) begin
            chk($sformatf("b2b_rvalid_%0d", k), 32'(bus.if_rvalid), 32'(1));
            chk($sformatf("b2b_rdata_%0d", k), 32'(bus.rdata), 32'(pattern(32'h20 + k - 1)));
         end
         tick();
      end

      // Reset lands on a granted data read.
      idle();
      bus.d_req = 1'b1; bus.d_addr = 16'h0030;
      settle();
      chk("rst_read_gnt", 32'(bus.d_gnt), 32'(1));
      #1 reset = 1'b0;
      tick();
      idle();
      settle();
      chk("rst_read_rvalid", 32'(bus.d_rvalid), 32'(0));
      tick();
      reset = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 16'h0021;
      settle();
      chk("post_rst_gnt", 32'(bus.if_gnt), 32'(1));
      tick();
      idle();
      settle();
      chk("post_rst_rvalid", 32'(bus.if_rvalid), 32'(1));
      chk("post_rst_rdata", 32'(bus.rdata), 32'(pattern(32'h21)));
      tick();

      // Randomized traffic; an ungranted request is held stable or dropped.
      for (int c = 0; c < 3000; c++) begin
         if (bus.if_req && m_win != 1) begin
            if ($urandom_range(0, 7) == 0) bus.if_req = 1'b0;
         end else begin
            bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = AW'($urandom);
         end
         if (bus.d_req && m_win != 2) begin
            if ($urandom_range(0, 7) == 0) bus.d_req = 1'b0;
         end else begin
            bus.d_req = 1'($urandom_range(0, 1)); bus.d_we = 1'($urandom_range(0, 1));
            bus.d_addr = AW'($urandom); bus.d_wdata = DW'($urandom);
         end
         if (bus.h_req && m_win != 3) begin
            if ($urandom_range(0, 15) == 0) bus.h_req = 1'b0;
         end else begin
            bus.h_req = 1'($urandom_range(0, 1)); bus.h_we = 1'($urandom_range(0, 1));
            bus.h_addr = AW'($urandom); bus.h_wdata = DW'($urandom);
         end
         settle();
         tick();
      end
      idle();
      settle();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter STARVE_MAX, default 7, host-wait cycles before host gets top priority (1..15).
REQ-004 The design SHALL have one clock, clk; reset is asynchronous and active-low, port name reset.
REQ-005 Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: async active-low reset.
- if_req, in, 1: instruction fetch read request.
- if_addr, in, ADDR_W: fetch address.
- if_gnt, out, 1: fetch granted this cycle.
- if_rvalid, out, 1: fetch read data valid on rdata.
- d_req, in, 1: CPU data request (ld/st).
- d_we, in, 1: data write enable (1 = st).
- d_addr, in, ADDR_W: data address.
- d_wdata, in, DATA_W: store data.
- d_gnt, out, 1: data granted this cycle.
- d_rvalid, out, 1: load data valid on rdata.
- h_req, in, 1: host/debug request.
- h_we, in, 1: host write enable.
- h_addr, in, ADDR_W: host address.
- h_wdata, in, DATA_W: host write data.
- h_gnt, out, 1: host granted this cycle.
- h_rvalid, out, 1: host read data valid on rdata.
- rdata, out, DATA_W: shared read data, equals mem_rdata.
- mem_en, out, 1: memory access this cycle.
- mem_we, out, 1: memory write.
- mem_addr, out, ADDR_W: memory address.
- mem_wdata, out, DATA_W: memory write data.
- mem_rdata, in, DATA_W: synchronous memory read data, 1-cycle latency.
- cpu_stall, out, 1: CPU must hold its fetch/data request.

Function
REQ-006 Grants SHALL be combinational from requests and the starvation counter; at most one of if_gnt/d_gnt/h_gnt high per cycle; a grant is given only to an asserted request.
REQ-007 Normal priority SHALL be data > fetch > host.
REQ-008 When starve_cnt == STARVE_MAX and h_req = 1, host SHALL win over data and fetch.
REQ-009 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle h_req = 1 and h_gnt = 0, and clear to 0 when h_gnt = 1 or h_req = 0.
REQ-010 mem_en SHALL equal OR of grants; mem_addr/mem_we/mem_wdata SHALL mux from the granted requester (fetch: we = 0); idle: addr/wdata 0, we 0.
REQ-011 A granted read SHALL produce exactly one rvalid pulse to its owner in the following cycle; writes produce no rvalid.
REQ-012 Owner SHALL be stored in a registered 2-bit state {NONE, IF, D, H}, loaded every cycle from the grant (NONE for no grant or write); rvalid outputs decode this register.
REQ-013 Back-to-back grants every cycle SHALL be supported with no bubble; requests held high without a grant SHALL keep their address/data stable (requester obligation).
REQ-014 cpu_stall SHALL be (if_req & ~if_gnt) | (d_req & ~d_gnt).
REQ-015 Requesters may drop req without ever being granted; no state other than starve_cnt SHALL be affected.

Reset
REQ-016 While reset = 0: owner = NONE, starve_cnt = 0, all rvalid = 0; grants and mem_* follow REQ-006/010 with no requests, i.e. 0.
REQ-017 A read granted in the cycle reset asserts SHALL produce no rvalid; after release, the first edge SHALL be able to grant.

Structure
REQ-018 Shared package SHALL hold the owner enum (NONE, IF, D, H) and default width constants.
REQ-019 One sub-module, mem_arb_starve_cnt (saturating counter with clear), is natural; all else in mem_arbiter.

Verification
REQ-020 if_req = 1 alone, if_addr = 0x0010, mem returns 0xABCD -> if_gnt same cycle, mem_addr = 0x0010, if_rvalid = 1 and rdata = 0xABCD next cycle.
REQ-021 if_req = d_req = 1, d_we = 1, d_addr = 0x0200, d_wdata = 0x1234 -> d_gnt, mem_we = 1, cpu_stall = 1, no rvalid; fetch granted next cycle.
REQ-022 h_req held with d_req held for 10 cycles -> h_gnt first in cycle 8 (starve_cnt = 7), then starve_cnt = 0.
REQ-023 Alternating fetch reads every cycle for 4 cycles -> 4 consecutive if_rvalid pulses, no bubbles.
REQ-024 Reset asserted in the cycle of a d_gnt read -> d_rvalid stays 0; owner = NONE after release.
